// File: rtl/spi_flash_reader_pkg.sv
// spi_flash_reader_pkg: peripheral register map, status bits, flash opcode and state encodings
package spi_flash_reader_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_SPEED = 2'd2;
  localparam int STAT_BUSY = 5;
  localparam int STAT_RECNEW = 1;
  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  typedef enum logic [2:0] {S_IDLE, S_SPEED, S_CS_SETUP, S_RUN, S_DRAIN, S_CS_HOLD, S_DONE} state_e;
  typedef enum logic [1:0] {ACC_SPEED, ACC_PUSH, ACC_POP, ACC_STAT} acc_e;
  function automatic logic [7:0] tx_byte(input logic [16:0] sent, input logic [23:0] a);
    return sent == 17'd0 ? FLASH_CMD_READ : sent == 17'd1 ? a[23:16] :
           sent == 17'd2 ? a[15:8] : sent == 17'd3 ? a[7:0] : 8'h00;
  endfunction
endpackage

// File: rtl/spi_bus_access.sv
// spi_bus_access: single-access bus master; latches one access on start and holds it until ack
module spi_bus_access (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        write_i,
  input  logic [1:0]  reg_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic        stb_o,
  output logic        we_o,
  output logic [1:0]  adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic [31:0] rdata_o,
  output logic        done_o
);
  logic        stb_q, we_q;
  logic [1:0]  adr_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (start_i) begin
      stb_q <= 1'b1;
      we_q  <= write_i;
      adr_q <= reg_i;
      sel_q <= sel_i;
      dat_q <= data_i;
    end else if (stb_q && ack_i) begin
      stb_q <= 1'b0;
    end
  assign stb_o   = stb_q;
  assign we_o    = we_q;
  assign adr_o   = adr_q;
  assign sel_o   = sel_q;
  assign dat_o   = dat_q;
  assign rdata_o = dat_i;
  assign done_o  = stb_q & ack_i;
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: turns one read request into SPI-flash READ traffic through the SPI peripheral
// and streams the received data bytes out with valid/ready.
module spi_flash_reader #(
  parameter logic [15:0] SPI_DIV    = 16'd5,
  parameter int          CS_DELAY   = 4,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        cs_n_o,
  output logic [1:0]  adr_o,
  output logic [3:0]  sel_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);
  import spi_flash_reader_pkg::*;
  state_e      state_q;
  acc_e        acc_q, acc_d;
  logic        start_q, iss_d, pending, pop_ok, push_ok, bdone;
  logic [23:0] addr_q;
  logic [16:0] len4_q, tx_left_q, rx_left_q;
  logic [2:0]  hdr_q;
  logic [4:0]  inflight_q;
  logic [3:0]  cnt_q;
  logic        recnew_q, cs_n_q, busy_q, done_q, valid_q;
  logic [7:0]  data_q;
  logic [31:0] rdata, wdata;
  logic        bwrite;
  logic [1:0]  breg;
  logic [3:0]  bsel;
  always_comb begin
    pending = start_q | stb_o;
    pop_ok  = recnew_q && rx_left_q != '0 && !(valid_q && !ready_i && hdr_q == '0);
    push_ok = tx_left_q != '0 && inflight_q < 5'(FIFO_DEPTH);
    iss_d   = (state_q == S_IDLE && req_i) || ((state_q == S_RUN || state_q == S_DRAIN) && !pending);
    acc_d   = state_q == S_IDLE ? ACC_SPEED : state_q == S_RUN && pop_ok ? ACC_POP :
              state_q == S_RUN && push_ok ? ACC_PUSH : ACC_STAT;
    bwrite  = acc_q == ACC_SPEED || acc_q == ACC_PUSH;
    breg    = acc_q == ACC_SPEED ? REG_SPEED : acc_q == ACC_STAT ? REG_STATUS : REG_DATA;
    bsel    = acc_q == ACC_SPEED ? 4'b0011 : acc_q == ACC_PUSH ? 4'b0001 : 4'b1111;
    wdata   = acc_q == ACC_SPEED ? {16'h0, SPI_DIV} :
              acc_q == ACC_PUSH ? {24'h0, tx_byte(len4_q - tx_left_q, addr_q)} : 32'h0;
  end
  spi_bus_access u_bus (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_q), .write_i(bwrite), .reg_i(breg),
    .sel_i(bsel), .data_i(wdata), .ack_i(ack_i), .dat_i(dat_i), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o), .rdata_o(rdata), .done_o(bdone)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= S_IDLE;
      acc_q      <= ACC_STAT;
      start_q    <= 1'b0;
      addr_q     <= '0;
      len4_q     <= '0;
      tx_left_q  <= '0;
      rx_left_q  <= '0;
      hdr_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      recnew_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      start_q <= iss_d;
      if (iss_d) acc_q <= acc_d;
      done_q <= 1'b0;
      if (valid_q && ready_i) valid_q <= 1'b0;
      if (bdone && acc_q == ACC_PUSH) begin
        tx_left_q  <= tx_left_q - 17'd1;
        inflight_q <= inflight_q + 5'd1;
      end
      if (bdone && acc_q == ACC_STAT) recnew_q <= rdata[STAT_RECNEW];
      // the first four echoes belong to the command/address header and are dropped
      if (bdone && acc_q == ACC_POP) begin
        if (hdr_q != '0) hdr_q <= hdr_q - 3'd1;
        else begin
          data_q  <= rdata[7:0];
          valid_q <= 1'b1;
        end
        rx_left_q  <= rx_left_q - 17'd1;
        inflight_q <= inflight_q - 5'd1;
        recnew_q   <= 1'b0;
      end
      case (state_q)
        S_IDLE: if (req_i) begin
          addr_q     <= addr_i;
          len4_q     <= {1'b0, len_i} + 17'd4;
          tx_left_q  <= {1'b0, len_i} + 17'd4;
          rx_left_q  <= {1'b0, len_i} + 17'd4;
          hdr_q      <= 3'd4;
          inflight_q <= '0;
          recnew_q   <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= S_SPEED;
        end
        S_SPEED: if (bdone) begin
          cs_n_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_CS_SETUP;
        end
        S_CS_SETUP: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(CS_DELAY - 1)) state_q <= S_RUN;
        end
        S_RUN: if (bdone && acc_q == ACC_POP && rx_left_q == 17'd1) state_q <= S_DRAIN;
        S_DRAIN: if (bdone && !rdata[STAT_BUSY]) begin
          cnt_q   <= '0;
          state_q <= S_CS_HOLD;
        end
        S_CS_HOLD: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(CS_DELAY - 1)) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign cs_n_o  = cs_n_q;
endmodule
